nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: performs a 4*NIBBLES-bit addition one nibble per
// clock through an external 4-bit ripple-carry adder (add_* ports).
// The carry is held in a register between nibbles, and done pulses once
// the full sum is ready.
// Optional: define OVERFLOW_DETECT_EN to add signed-overflow detection on
// ovf. When it is not defined, ovf is tied low.
module nibble_serial_add_ctrl #(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [3:0]   add_x,
    output logic [3:0]   add_y,
    output logic         add_cin,
    input  logic [3:0]   add_z,
    input  logic         add_cout,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [W-1:0]     sum_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;

    // Select the operand nibbles for the current slice, and merge the adder result into the sum.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        sum_d = sum_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a             = a_q[4*i +: 4];
                nib_b             = b_q[4*i +: 4];
                sum_d[4*i +: 4]   = add_z;
            end
        end
    end

    // Drive the adder only while running; keep its inputs quiet otherwise.
    always_comb begin
        add_x   = 4'h0;
        add_y   = 4'h0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_x   = nib_a;
            add_y   = nib_b;
            add_cin = carry_q;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;
`endif

    // Sequencer: capture operands, step through the nibbles, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        cout_q  <= add_cout;
                        done_q  <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (add_z[3] != a_q[W-1]);
`endif
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef OVERFLOW_DETECT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl. It uses a table of directed vectors, a
// reset-abort sequence, and randomized operations. Expected values come from
// plain wide-integer arithmetic.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int          BUDGET  = 20;

    typedef logic [W:0] val_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         inject;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   add_x;
    logic [3:0]   add_y;
    logic         add_cin;
    logic [3:0]   add_z;
    logic         add_cout;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_z    (add_z),
        .add_cout (add_cout),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    // The external 4-bit ripple-carry adder
    assign {add_cout, add_z} = 5'(add_x) + 5'(add_y) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input val_t act, input val_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic val_t model_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return val_t'(x) + val_t'(y) + val_t'(c);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        val_t s;
        s = model_full(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    // Carry into nibble k: the carry-out of the low 4*k bits plus cin
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input int k);
        val_t m;
        val_t t;
        m = (val_t'(1) << (4 * k)) - val_t'(1);
        t = (val_t'(x) & m) + (val_t'(y) & m) + val_t'(c);
        return t[4 * k];
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] x, input int k);
        return 4'(x >> (4 * k));
    endfunction

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input logic inject);
        int   done_cyc;
        logic eo;
        done_cyc = 0;
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (inject && cyc == 2) begin
                start = 1'b1;
                a = W'(16'hAAAA);
            end
            if (inject && cyc == 3) start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            check({name, " busy"}, val_t'(busy), val_t'(1));
            if (cyc <= int'(NIBBLES)) begin
                check({name, " add_x"},   val_t'(add_x),   val_t'(nib(ta, cyc - 1)));
                check({name, " add_y"},   val_t'(add_y),   val_t'(nib(tbv, cyc - 1)));
                check({name, " add_cin"}, val_t'(add_cin), val_t'(carry_into(ta, tbv, tc, cyc - 1)));
            end
        end
        check({name, " latency"}, val_t'(done_cyc), val_t'(NIBBLES + 1));
`ifdef OVERFLOW_DETECT_EN
        eo = exp_ovf;
`else
        eo = 1'b0;
`endif
        check({name, " sum"},        val_t'(sum),   val_t'(exp_sum));
        check({name, " cout"},       val_t'(cout),  val_t'(exp_cout));
        check({name, " ovf"},        val_t'(ovf),   val_t'(eo));
        check({name, " busy@done"},  val_t'(busy),  val_t'(1));
        check({name, " add_x@done"}, val_t'(add_x), val_t'(0));
        for (int p = 1; p <= 3; p++) begin
            @(negedge clk);
            check({name, " done after"}, val_t'(done), val_t'(0));
            check({name, " busy after"}, val_t'(busy), val_t'(0));
            check({name, " sum held"},   val_t'(sum),  val_t'(exp_sum));
            check({name, " cout held"},  val_t'(cout), val_t'(exp_cout));
            check({name, " ovf held"},   val_t'(ovf),  val_t'(eo));
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("reset sum",  val_t'(sum),  val_t'(0));
        check("reset cout", val_t'(cout), val_t'(0));
        check("reset ovf",  val_t'(ovf),  val_t'(0));
        check("reset busy", val_t'(busy), val_t'(0));
        check("reset done", val_t'(done), val_t'(0));
        check("reset add_x", val_t'(add_x), val_t'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].inject);
        end

        // Reset in the middle of an operation aborts it, and no done pulse follows
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort partial sum", val_t'(sum), val_t'(16'h0005));
        rst_n = 1'b0;
        #1;
        check("abort sum",     val_t'(sum),     val_t'(0));
        check("abort cout",    val_t'(cout),    val_t'(0));
        check("abort ovf",     val_t'(ovf),     val_t'(0));
        check("abort busy",    val_t'(busy),    val_t'(0));
        check("abort done",    val_t'(done),    val_t'(0));
        check("abort add_x",   val_t'(add_x),   val_t'(0));
        check("abort add_y",   val_t'(add_y),   val_t'(0));
        check("abort add_cin", val_t'(add_cin), val_t'(0));
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            check("abort no done", val_t'(done), val_t'(0));
        end
        rst_n = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            check("post-abort idle done", val_t'(done), val_t'(0));
            check("post-abort idle busy", val_t'(busy), val_t'(0));
        end
        do_op("after reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Randomized operations checked against wide-integer arithmetic
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            val_t         full;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            full = model_full(ra, rb, rc);
            do_op($sformatf("rand%0d", i), ra, rb, rc, full[W-1:0], full[W],
                  model_ovf(ra, rb, rc), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
